duty_slew: RTL
==============

# duty_slew

Duty-cycle slew limiter that sits directly upstream of the 10-bit PWM generator and drives its duty input. Accepts a target duty over a valid/ready handshake and moves its duty output toward that target by at most STEP counts per 1024-cycle PWM period. Updates land only at period boundaries, so the PWM never sees a mid-period duty change. Its internal period counter runs in lockstep with the PWM counter when both leave reset on the same clock edge.

## Interface
- STEP, default 8: maximum duty change per period; legal range 1..1023.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- tgt  in  10  requested target duty.
- tgt_vld  in  1  tgt valid.
- tgt_rdy  out  1  block can accept a target; transfer occurs on a clock edge where tgt_vld && tgt_rdy.
- duty  out  10  registered duty to the PWM generator.
- busy  out  1  high while slewing (state SLEW).
- period_tick  out  1  high during the cycle where the period counter equals 1023.

## Operation
- Period counter cnt: 10-bit, increments every cycle, wraps 1023 -> 0. Boundary cycle = cnt==1023.
- Target register tgt_q (10-bit) loads tgt on every accepted transfer.
- FSM states:
  - IDLE: tgt_rdy=1, busy=0. Accept -> SLEW.
  - SLEW: busy=1, tgt_rdy=0 (see Configuration).
- Boundary cycle in SLEW updates duty:
  - diff = |tgt_q - duty|, computed at 11 bits.
  - If diff <= STEP: duty <= tgt_q, go to IDLE.
  - Else if tgt_q > duty: duty <= duty + STEP.
  - Else: duty <= duty - STEP.
  - No overflow or underflow is possible. Stepping occurs only when diff > STEP, so results stay in 0..1023.
- A target equal to the current duty still enters SLEW. It completes at the next boundary with duty unchanged.
- Accept in IDLE on a boundary cycle: no update at that boundary. The first update occurs at the following boundary, 1024 cycles later.
- Boundary cycles in IDLE: duty holds.

## Timing
- Reset values (on a clock edge with rst=1): cnt=0, duty=0, tgt_q=0, state IDLE, tgt_rdy=1, busy=0, period_tick=0.
- rst has priority over all other activity. Asserting rst mid-slew abandons the target, forces duty=0 and returns to IDLE.
- Handshake latency: on a transfer edge in IDLE, busy=1 and tgt_rdy=0 from the next cycle.
- Update latency: duty changes on the clock edge that ends a boundary cycle. The new value is present when cnt==0, which is the first cycle of the new PWM period.
- Completion: busy=0 and tgt_rdy=1 in the cycle after the final-step edge.
- Worst-case slew time: ceil(1023/STEP) periods.
- period_tick is a decode of registered cnt, and equals 1 in exactly one cycle of every 1024.

## Configuration
- RETARGET_EN defined:
  - tgt_rdy=1 in both states, so the target may be replaced mid-slew.
  - A transfer during SLEW overwrites tgt_q, and state stays SLEW.
  - A transfer on a boundary cycle: that boundary's step uses the old tgt_q, and the new value is loaded on the same edge.
  - The FSM remains in SLEW even if that step reached the old target.
- RETARGET_EN undefined:
  - tgt_rdy=0 in SLEW.
  - tgt_vld is ignored in SLEW, and tgt_q is stable until IDLE.

## Test plan
1. Assert rst for 2 cycles, then release -> duty=0, busy=0, tgt_rdy=1, period_tick=0. First period_tick occurs 1023 cycles after release.
2. STEP=8, tgt=100 accepted at cycle 5 after reset:
   - duty steps 8,16,...,96,100 at successive boundaries, 13 updates in total.
   - Each new value appears when cnt==0.
   - busy falls after duty reaches 100.
3. From duty=100, tgt=90 -> duty 92 at the first boundary, 90 at the second, then IDLE.
4. tgt equal to the current duty (0), accepted on a boundary cycle:
   - No change at that boundary.
   - busy=1 for one full period, and duty stays 0.
5. Mid-slew to 100 with duty=40, drive tgt=0 with tgt_vld=1:
   - Without RETARGET_EN: tgt_rdy=0, request ignored, duty continues to 100.
   - With RETARGET_EN: next boundary gives duty=32, then ramps down to 0.
6. Assert rst while duty=56 and slewing up -> next cycle duty=0, IDLE, tgt_rdy=1, cnt=0.

Source files
------------

// File: rtl/duty_slew.sv
// duty_slew -- duty-cycle slew limiter feeding a 10-bit PWM generator.
//
// Accepts a target duty over a valid/ready handshake and walks the registered
// duty output toward it by at most STEP counts per 1024-cycle PWM period.
// Duty only changes on the edge that ends the period (cnt==1023), so the PWM
// sees the new value from the first cycle of the next period.
//
// Optional feature macro: RETARGET_EN
//   defined   : tgt_rdy stays high while slewing; a new target overwrites the
//               old one mid-slew and the FSM stays in SLEW.
//   undefined : tgt_rdy is low while slewing; requests are ignored until IDLE.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   tgt[9:0]    in   requested target duty
//   tgt_vld     in   target valid
//   tgt_rdy     out  target can be accepted this cycle
//   duty[9:0]   out  registered duty to the PWM generator
//   busy        out  high while slewing
//   period_tick out  high while the period counter equals 1023
module duty_slew #(
  parameter int STEP = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] tgt,
  input  logic       tgt_vld,
  output logic       tgt_rdy,
  output logic [9:0] duty,
  output logic       busy,
  output logic       period_tick
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SLEW = 1'b1;

  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [9:0]  STEP_D = 10'(STEP);

  logic [0:0]  state;
  logic [9:0]  cnt;
  logic [9:0]  tgt_q;
  logic        xfer;
  logic        bnd;
  logic [10:0] diff;
  logic        reach;
  logic [9:0]  duty_nxt;

`ifdef RETARGET_EN
  assign tgt_rdy = 1'b1;
`else
  assign tgt_rdy = (state == IDLE);
`endif

  assign busy        = (state == SLEW);
  assign period_tick = (cnt == 10'd1023);
  assign bnd         = period_tick;
  assign xfer        = tgt_vld && tgt_rdy;

  // Distance to target at 11 bits; stepping only happens when diff > STEP,
  // so duty +/- STEP can never leave 0..1023.
  always_comb begin
    diff = (tgt_q >= duty) ? ({1'b0, tgt_q} - {1'b0, duty})
                           : ({1'b0, duty} - {1'b0, tgt_q});
    reach = (diff <= STEP_W);
    duty_nxt = duty;
    if (reach)             duty_nxt = tgt_q;
    else if (tgt_q > duty) duty_nxt = duty + STEP_D;
    else                   duty_nxt = duty - STEP_D;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      duty  <= '0;
      tgt_q <= '0;
      state <= IDLE;
    end else begin
      cnt <= cnt + 10'd1;
      // A boundary-cycle retarget still steps against the old tgt_q: the
      // step below reads tgt_q before this load takes effect.
      if (xfer) tgt_q <= tgt;
      case (state)
        IDLE: begin
          // Accepting on a boundary does not update at that boundary.
          if (xfer) state <= SLEW;
        end
        SLEW: begin
          if (bnd) begin
            duty <= duty_nxt;
            if (reach && !xfer) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
